// File: rtl/uart_rx.sv
// uart_rx -- UART receive path.
//
// Deserializes an asynchronous serial line into parallel words.
// Frame: 1 start bit (0), DATA_W data bits LSB first, optional parity bit, 1 stop bit (1).
// Each completed frame is presented as a one-clock o_valid strobe.
// o_data and the error flags update in that same cycle and hold until the next strobe.
// Frames with errors are still presented; the consumer decides whether to drop them.
//
// Parameters:
//   BAUD_DIV   clock cycles per bit (even, >= 4)
//   DATA_W     data bits per frame
//   PARITY_EN  1 = parity bit present and checked
//   PARITY_ODD 1 = odd parity, 0 = even parity
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   i_rx         serial line (asynchronous, idles high)
//   o_data       last received word
//   o_valid      one-clock strobe, frame complete
//   o_parity_err parity mismatch in last frame
//   o_frame_err  stop bit sampled 0 in last frame
//   o_busy       high while a frame is being received
module uart_rx #(
  parameter int BAUD_DIV   = 16,
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rx,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_busy
);

  localparam int   HALF    = BAUD_DIV / 2;
  localparam int   CNT_W   = $clog2(BAUD_DIV);
  localparam int   BIT_W   = $clog2(DATA_W) + 1;
  localparam logic HAS_PAR = (PARITY_EN != 0);
  localparam logic ODD_PAR = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    WAIT_HIGH, IDLE, START, DATA, PARITY, STOP, DONE
  } state_t;

  state_t             state_reg, state_next;
  logic               rx_meta_reg, rx_s_reg;
  logic [1:0]         settle_reg;
  logic [CNT_W-1:0]   baud_reg, baud_next;
  logic [BIT_W-1:0]   bit_reg, bit_next;
  logic [DATA_W-1:0]  shift_reg, shift_next;
  logic               par_err_reg, par_err_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic               pe_reg, pe_next;
  logic               fe_reg, fe_next;

  wire baud_half = (baud_reg == CNT_W'(HALF - 1));
  wire baud_full = (baud_reg == CNT_W'(BAUD_DIV - 1));

  // Two-flop synchronizer. Both flops reset high, so after reset they hold a
  // stale "1" until the live line has been clocked through. settle_reg marks when
  // rx_s_reg really reflects i_rx. Without it, a line held low through reset would
  // look like an idle-high line followed by a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      settle_reg  <= 2'b00;
    end else begin
      rx_meta_reg <= i_rx;
      rx_s_reg    <= rx_meta_reg;
      settle_reg  <= {settle_reg[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= WAIT_HIGH;
      baud_reg    <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      par_err_reg <= 1'b0;
      data_reg    <= '0;
      pe_reg      <= 1'b0;
      fe_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      par_err_reg <= par_err_next;
      data_reg    <= data_next;
      pe_reg      <= pe_next;
      fe_reg      <= fe_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg + CNT_W'(1);
    bit_next     = bit_reg;
    shift_next   = shift_reg;
    par_err_next = par_err_reg;
    data_next    = data_reg;
    pe_next      = pe_reg;
    fe_next      = fe_reg;

    case (state_reg)
      WAIT_HIGH: begin
        baud_next = '0;
        if (settle_reg[1] && rx_s_reg) state_next = IDLE;
      end

      IDLE: begin
        baud_next = '0;
        if (!rx_s_reg) state_next = START;
      end

      START: begin
        // Mid-point of the start bit: a high line here was a glitch.
        if (baud_half) begin
          baud_next    = '0;
          bit_next     = '0;
          par_err_next = 1'b0;
          state_next   = rx_s_reg ? IDLE : DATA;
        end
      end

      DATA: begin
        if (baud_full) begin
          baud_next  = '0;
          shift_next = {rx_s_reg, shift_reg[DATA_W-1:1]};
          bit_next   = bit_reg + BIT_W'(1);
          if (bit_reg == BIT_W'(DATA_W - 1))
            state_next = HAS_PAR ? PARITY : STOP;
        end
      end

      PARITY: begin
        if (baud_full) begin
          baud_next    = '0;
          par_err_next = rx_s_reg ^ (^shift_reg) ^ ODD_PAR;
          state_next   = STOP;
        end
      end

      STOP: begin
        // Result registers load here so they change together with o_valid.
        if (baud_full) begin
          baud_next  = '0;
          data_next  = shift_reg;
          pe_next    = HAS_PAR & par_err_reg;
          fe_next    = !rx_s_reg;
          state_next = DONE;
        end
      end

      DONE: begin
        // A low stop bit means a break or stuck line; wait for idle before re-arming.
        baud_next  = '0;
        state_next = fe_reg ? WAIT_HIGH : IDLE;
      end

      default: state_next = WAIT_HIGH;
    endcase
  end

  assign o_data       = data_reg;
  assign o_parity_err = pe_reg;
  assign o_frame_err  = fe_reg;
  assign o_valid      = (state_reg == DONE);
  assign o_busy       = (state_reg == START) || (state_reg == DATA) ||
                        (state_reg == PARITY) || (state_reg == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with default parameters
// (BAUD_DIV=16, DATA_W=8, even parity enabled).
module tb_uart_rx;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid, o_parity_err, o_frame_err, o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         vt[$];
  logic [7:0] vd[$];
  logic       vpe[$];
  logic       vfe[$];

  uart_rx #(.BAUD_DIV(BD), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
    .o_parity_err(o_parity_err), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Record every strobe with the index of the edge that raised it.
  always @(negedge clk) begin
    if (o_valid) begin
      vt.push_back(cyc);
      vd.push_back(o_data);
      vpe.push_back(o_parity_err);
      vfe.push_back(o_frame_err);
      $display("[TB] valid @%0d data=%02h perr=%0b ferr=%0b", cyc, o_data, o_parity_err, o_frame_err);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    vt.delete(); vd.delete(); vpe.delete(); vfe.delete();
  endtask

  // Hold the current line level for one bit period; ends #1 after an edge.
  task automatic wait_bit();
    repeat (BD) @(posedge clk);
    #1;
  endtask

  // Caller must be #1 after a posedge. e = edge index just before the start bit is driven.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, output int e);
    e = cyc;
    i_rx = 1'b0; wait_bit();
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i]; wait_bit();
    end
    i_rx = p; wait_bit();
    i_rx = s; wait_bit();
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Check that exactly one strobe was seen, carrying the given word and flags.
  task automatic check_one(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check({tag, "_count"}, vt.size(), 1);
    if (vt.size() >= 1) begin
      check({tag, "_data"}, vd[0], d);
      check({tag, "_perr"}, vpe[0], pe);
      check({tag, "_ferr"}, vfe[0], fe);
    end
  endtask

  int e0, e1, busy_cnt;

  initial begin
    i_rx = 1'b1;
    rst  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_data",  o_data, 0);
    check("rst_valid", o_valid, 0);
    check("rst_perr",  o_parity_err, 0);
    check("rst_ferr",  o_frame_err, 0);
    check("rst_busy",  o_busy, 0);
    rst = 1'b1;
    idle(10);

    // 0xA5: four ones, so the even parity bit is 0.
    // Latency: flop1 at e+1, rx_s low after e+2, FSM leaves IDLE at e+3 (T0).
    // The stop sample is at T0+168, so o_valid is seen at edge index e+171.
    clear_q();
    send_frame(8'hA5, 1'b0, 1'b1, e0);
    idle(20);
    check_one("a5", 8'hA5, 1'b0, 1'b0);
    if (vt.size() >= 1) check("a5_time", vt[0], e0 + 171);

    // 0x3C has four ones; a parity bit of 1 is wrong for even parity.
    clear_q();
    send_frame(8'h3C, 1'b1, 1'b1, e0);
    idle(20);
    check_one("3c", 8'h3C, 1'b1, 1'b0);

    // 0x55 with a low stop bit, then the line stays low for 40 bit times.
    clear_q();
    send_frame(8'h55, 1'b0, 1'b0, e0);
    i_rx = 1'b0;
    repeat (40 * BD) @(posedge clk);
    #1;
    check_one("brk", 8'h55, 1'b0, 1'b1);
    idle(40);
    check("brk_no_more", vt.size(), 1);
    clear_q();
    send_frame(8'h81, 1'b0, 1'b1, e0);
    idle(20);
    check_one("81", 8'h81, 1'b0, 1'b0);

    // A 4-clock low glitch: busy for half a bit, then back to IDLE with no strobe.
    clear_q();
    busy_cnt = 0;
    i_rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      busy_cnt += int'(o_busy);
      if (i == 3) i_rx = 1'b1;
    end
    check("glitch_busy", busy_cnt, BD / 2);
    check("glitch_valid", vt.size(), 0);
    idle(5);

    // Back-to-back 0x00 then 0xFF (eight ones, so even parity is 0), no gap.
    clear_q();
    send_frame(8'h00, 1'b0, 1'b1, e0);
    send_frame(8'hFF, 1'b0, 1'b1, e1);
    idle(20);
    check("b2b_count", vt.size(), 2);
    if (vt.size() >= 2) begin
      check("b2b_gap",   vt[1] - vt[0], 11 * BD);
      check("b2b_d0",    vd[0], 8'h00);
      check("b2b_d1",    vd[1], 8'hFF);
      check("b2b_err0",  {vpe[0], vfe[0]}, 2'b00);
      check("b2b_err1",  {vpe[1], vfe[1]}, 2'b00);
    end

    // Reset in the middle of data bit 4 of 0x0F; release while the line is low.
    clear_q();
    i_rx = 1'b0; wait_bit();                 // start bit
    for (int i = 0; i < 4; i++) begin
      i_rx = 1'b1; wait_bit();               // data bits 0..3 = 1
    end
    i_rx = 1'b0;                             // data bit 4 = 0
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_data", o_data, 0);
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      i_rx = 1'b0; wait_bit();               // data bits 5..7 = 0
    end
    i_rx = 1'b0; wait_bit();                 // parity
    i_rx = 1'b1; wait_bit();                 // stop
    idle(40);
    check("mid_rst_novalid", vt.size(), 0);
    // 0x7E: six ones, so the even parity bit is 0.
    send_frame(8'h7E, 1'b0, 1'b1, e0);
    idle(20);
    check_one("7e", 8'h7E, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
